rns_to_binary_seq: RTL and testbench



---
 rtl/rns_to_binary_seq_pkg.sv | 24 ++
 rtl/rns_to_binary_seq_if.sv | 27 ++
 rtl/rns_to_binary_seq_mod_counter.sv | 38 +++
 rtl/rns_to_binary_seq.sv | 132 +++++++++++++
 tb/tb_rns_to_binary_seq.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/rns_to_binary_seq_pkg.sv
// Shared types and constants for the sequential residue-to-binary converter.
// The validity helper is shared so every modulus/residue pair is screened the same way.
package rns_pkg;

  localparam int RNS_RES_W = 3;
  localparam int RNS_BIN_W = 7;
  localparam logic [RNS_BIN_W-1:0] RNS_X_MAX = 7'd127;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [RNS_RES_W-1:0] res_t;
  typedef logic [RNS_BIN_W-1:0] bin_t;

  // A modulus below 2 or a residue not smaller than its modulus has no solution.
  function automatic logic res_invalid(input res_t residue, input res_t modulus);
    return (modulus < 3'd2) || (residue >= modulus);
  endfunction

endpackage

// File: rtl/rns_to_binary_seq_if.sv
// Request/result bundle between the RNS arithmetic stage and the converter.
interface rns_to_binary_seq_if;
  import rns_pkg::*;

  logic start;
  res_t residue1;
  res_t residue2;
  res_t residue3;
  res_t moduli1;
  res_t moduli2;
  res_t moduli3;
  logic busy;
  logic done;
  bin_t binary;
  logic error;

  modport master (
    output start, residue1, residue2, residue3, moduli1, moduli2, moduli3,
    input  busy, done, binary, error
  );

  modport slave (
    input  start, residue1, residue2, residue3, moduli1, moduli2, moduli3,
    output busy, done, binary, error
  );

endinterface

// File: rtl/rns_to_binary_seq_mod_counter.sv
// Wrap-around residue counter: tracks x mod modulus without a divider.
module mod_counter
  import rns_pkg::*;
#(
  parameter int W = RNS_RES_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic [W:0]   inc_s;

  // One extra bit so that modulus 2^W-1 wraps from 2^W-2 without overflow aliasing.
  always_comb begin
    inc_s = {1'b0, count_r} + {{W{1'b0}}, 1'b1};
  end

  // Counter register with synchronous clear taking priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      count_r <= (inc_s == {1'b0, modulus}) ? {W{1'b0}} : inc_s[W-1:0];
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/rns_to_binary_seq.sv
// Sequential residue-to-binary converter: steps x upward one candidate per cycle
// alongside three modular counters and stops at the first x matching all residues.
module rns_to_binary_seq
  import rns_pkg::*;
(
  input logic                clk,
  input logic                rst,
  rns_to_binary_seq_if.slave bus
);

  state_t state_r;
  res_t   r1_r, r2_r, r3_r;
  res_t   m1_r, m2_r, m3_r;
  res_t   c1_s, c2_s, c3_s;
  bin_t   x_r;
  bin_t   binary_r;
  logic   busy_r;
  logic   done_r;
  logic   error_r;
  logic   match_s;
  logic   invalid_s;
  logic   clr_s;
  logic   en_s;

  mod_counter #(.W(RNS_RES_W)) u_cnt1 (
    .clk(clk), .rst(rst), .clr(clr_s), .en(en_s), .modulus(m1_r), .count(c1_s)
  );
  mod_counter #(.W(RNS_RES_W)) u_cnt2 (
    .clk(clk), .rst(rst), .clr(clr_s), .en(en_s), .modulus(m2_r), .count(c2_s)
  );
  mod_counter #(.W(RNS_RES_W)) u_cnt3 (
    .clk(clk), .rst(rst), .clr(clr_s), .en(en_s), .modulus(m3_r), .count(c3_s)
  );

  // Candidate compare and counter control decoded from the current state.
  always_comb begin
    match_s   = (c1_s == r1_r) && (c2_s == r2_r) && (c3_s == r3_r);
    invalid_s = res_invalid(r1_r, m1_r) || res_invalid(r2_r, m2_r) || res_invalid(r3_r, m3_r);
    clr_s     = 1'b0;
    en_s      = 1'b0;
    case (state_r)
      CHECK: begin
        clr_s = 1'b1;
      end
      SEARCH: begin
        en_s = !match_s && (x_r != RNS_X_MAX);
      end
      default: begin
        clr_s = 1'b0;
        en_s  = 1'b0;
      end
    endcase
  end

  // Control FSM with input latches, x counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      r1_r     <= 3'd0;
      r2_r     <= 3'd0;
      r3_r     <= 3'd0;
      m1_r     <= 3'd0;
      m2_r     <= 3'd0;
      m3_r     <= 3'd0;
      x_r      <= 7'd0;
      binary_r <= 7'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            r1_r    <= bus.residue1;
            r2_r    <= bus.residue2;
            r3_r    <= bus.residue3;
            m1_r    <= bus.moduli1;
            m2_r    <= bus.moduli2;
            m3_r    <= bus.moduli3;
            busy_r  <= 1'b1;
            state_r <= CHECK;
          end else begin
            state_r <= IDLE;
          end
        end
        CHECK: begin
          if (invalid_s) begin
            binary_r <= 7'd0;
            error_r  <= 1'b1;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else begin
            x_r     <= 7'd0;
            state_r <= SEARCH;
          end
        end
        SEARCH: begin
          if (match_s) begin
            binary_r <= x_r;
            error_r  <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else if (x_r == RNS_X_MAX) begin
            binary_r <= 7'd0;
            error_r  <= 1'b1;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else begin
            x_r <= x_r + 7'd1;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.binary = binary_r;
  assign bus.error  = error_r;

endmodule

// File: tb/tb_rns_to_binary_seq.sv
// Scoreboard bench for rns_to_binary_seq: stimulus pushes hand-computed results,
// a negedge monitor pops and checks them whenever done is presented.
module tb_rns_to_binary_seq;
  import rns_pkg::*;

  typedef struct {
    bin_t bin;
    logic err;
    int   e0;
    int   done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  logic busy_gap = 1'b0;
  logic post_done = 1'b0;
  exp_t sb[$];
  exp_t cur;

  rns_to_binary_seq_if bus();

  rns_to_binary_seq dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      busy_gap  = 1'b0;
      post_done = 1'b0;
    end else begin
      if (post_done) begin
        chk("done_one_cycle", int'(bus.done), 0);
        chk("busy_low_after_done", int'(bus.busy), 0);
        post_done = 1'b0;
      end
      if (sb.size() > 0 && cyc >= sb[0].e0 && !bus.busy) busy_gap = 1'b1;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          cur = sb.pop_front();
          chk("binary", int'(bus.binary), int'(cur.bin));
          chk("error", int'(bus.error), int'(cur.err));
          chk("done_latency", cyc - cur.e0, cur.done_cyc - cur.e0);
          chk("busy_throughout", int'(busy_gap), 0);
          busy_gap  = 1'b0;
          post_done = 1'b1;
        end
        done_cnt++;
      end
    end
  end

  task automatic convert(input string name,
                         input res_t r1, input res_t r2, input res_t r3,
                         input res_t m1, input res_t m2, input res_t m3,
                         input bin_t exp_bin, input logic exp_err,
                         input int lat, input int hold);
    int   prev;
    int   waited;
    exp_t e;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.residue1 = r1;
    bus.residue2 = r2;
    bus.residue3 = r3;
    bus.moduli1  = m1;
    bus.moduli2  = m2;
    bus.moduli3  = m3;
    @(posedge clk);
    #1;
    e.bin      = exp_bin;
    e.err      = exp_err;
    e.e0       = cyc;
    e.done_cyc = cyc + lat;
    prev       = done_cnt;
    sb.push_back(e);
    // Change inputs after acceptance: only the latched copies may matter.
    bus.residue1 = 3'd0;
    bus.residue2 = 3'd0;
    bus.residue3 = 3'd0;
    bus.moduli1  = 3'd1;
    bus.moduli2  = 3'd7;
    bus.moduli3  = 3'd7;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
    end
    bus.start = 1'b0;
    waited = 0;
    while (done_cnt == prev && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (done_cnt == prev) begin
      chk($sformatf("%s_timeout", name), 0, 1);
      sb.delete();
    end
  endtask

  task automatic reset_mid();
    int prev;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.residue1 = 3'd2;
    bus.residue2 = 3'd4;
    bus.residue3 = 3'd6;
    bus.moduli1  = 3'd3;
    bus.moduli2  = 3'd5;
    bus.moduli3  = 3'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    prev = done_cnt;
    // Edge E0+42 compares x=40; reset lands between edges.
    repeat (42) @(posedge clk);
    #2;
    chk("busy_before_rst", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_binary", int'(bus.binary), 0);
    chk("rst_error", int'(bus.error), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (130) @(negedge clk);
    #1;
    chk("no_done_after_rst", done_cnt - prev, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.residue1 = 3'd0;
    bus.residue2 = 3'd0;
    bus.residue3 = 3'd0;
    bus.moduli1  = 3'd0;
    bus.moduli2  = 3'd0;
    bus.moduli3  = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_binary", int'(bus.binary), 0);
    chk("reset_error", int'(bus.error), 0);
    rst = 1'b0;

    convert("v23_hold",   3'd2, 3'd3, 3'd2, 3'd3, 3'd5, 3'd7, 7'd23,  1'b0, 25,  10);
    convert("v0",         3'd0, 3'd0, 3'd0, 3'd3, 3'd5, 3'd7, 7'd0,   1'b0, 2,   0);
    convert("v104",       3'd2, 3'd4, 3'd6, 3'd3, 3'd5, 3'd7, 7'd104, 1'b0, 106, 0);
    convert("mod1",       3'd0, 3'd0, 3'd0, 3'd1, 3'd5, 3'd7, 7'd0,   1'b1, 1,   0);
    convert("v23_again",  3'd2, 3'd3, 3'd2, 3'd3, 3'd5, 3'd7, 7'd23,  1'b0, 25,  0);
    convert("res_ge_mod", 3'd3, 3'd0, 3'd0, 3'd3, 3'd5, 3'd7, 7'd0,   1'b1, 1,   0);
    convert("mod0",       3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd7, 7'd0,   1'b1, 1,   0);
    convert("nomatch",    3'd1, 3'd0, 3'd0, 3'd2, 3'd4, 3'd6, 7'd0,   1'b1, 129, 0);
    convert("wrap7",      3'd2, 3'd0, 3'd0, 3'd7, 3'd2, 3'd3, 7'd30,  1'b0, 32,  0);
    convert("v127",       3'd1, 3'd1, 3'd2, 3'd7, 3'd6, 3'd5, 7'd127, 1'b0, 129, 0);
    reset_mid();
    convert("after_rst",  3'd2, 3'd3, 3'd2, 3'd3, 3'd5, 3'd7, 7'd23,  1'b0, 25,  0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
